// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS data bits LSB first, runtime parity
// and stop-bit count, paced by an OVERSAMPLE x baud tick, with a completion pulse.
module uart_tx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 b_tick,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);
  localparam int unsigned TICK_W = CNT_W + 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 stop2_q, stop2_d;
  logic                 par_q, par_d;
  logic                 tx_d, busy_d, done_d;
  logic                 bit_end, stop_end;

  // Bit-period boundaries; the stop phase may span two bit periods
  always_comb begin
    bit_end  = (tick_q == TICK_W'(OVERSAMPLE - 1));
    stop_end = stop2_q ? (tick_q == TICK_W'(2 * OVERSAMPLE - 1)) : bit_end;
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pmode_d = pmode_q;
    stop2_d = stop2_q;
    par_d   = par_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        if (start) begin
          shift_d = tx_data;
          pmode_d = parity_mode;
          stop2_d = stop2;
          // Parity taken from the captured word, before any shifting
          unique case (parity_mode)
            2'b01:   par_d = ^tx_data;
            2'b10:   par_d = ~^tx_data;
            2'b11:   par_d = 1'b1;
            default: par_d = 1'b0;
          endcase
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (b_tick) begin
          tick_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (b_tick) begin
          if (bit_end) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      DATA: begin
        if (b_tick) begin
          if (bit_end) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
              state_d = (pmode_q != 2'b00) ? PARITY : STOP;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      PARITY: begin
        if (b_tick) begin
          if (bit_end) begin
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      STOP: begin
        if (b_tick) begin
          if (stop_end) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx stays a pure register
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      pmode_q <= '0;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pmode_q <= pmode_d;
      stop2_q <= stop2_d;
      par_q   <= par_d;
      tx      <= tx_d;
      tx_busy <= busy_d;
      tx_done <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a default 8-bit/16x instance and a 7-bit/8x instance,
// each with a serial-line monitor checking frames against a queue of expected payloads.
module tb_uart_tx_cfg;

  typedef struct {
    logic [8:0] data;
    logic [1:0] pm;
    logic       s2;
  } frame_t;

  logic       clk;
  logic       reset;
  logic       b_tick;
  logic       tick_en;
  logic       start_a, start_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [1:0] pm;
  logic       s2;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;
  logic       tick_at_pos, rst_at_pos;

  frame_t q0[$];
  frame_t q1[$];
  int     pushed[2];
  int     seen[2];
  int     n_checks;
  int     n_errors;
  int     div;

  uart_tx_cfg u_dut_a (
    .clk(clk), .reset(reset), .b_tick(b_tick), .start(start_a), .tx_data(data_a),
    .parity_mode(pm), .stop2(s2), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(8)) u_dut_b (
    .clk(clk), .reset(reset), .b_tick(b_tick), .start(start_b), .tx_data(data_b),
    .parity_mode(pm), .stop2(s2), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick every 4 clk; tick_en stalls it
  initial begin
    b_tick = 1'b0;
    div    = 0;
    forever begin
      @(negedge clk);
      div    = (div + 1) % 4;
      b_tick = tick_en && (div == 0);
    end
  end

  always @(posedge clk) begin
    tick_at_pos <= b_tick;
    rst_at_pos  <= reset;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic line_tx(input int u);
    return (u == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic line_busy(input int u);
    return (u == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic line_done(input int u);
    return (u == 0) ? done_a : done_b;
  endfunction

  task automatic run_monitor(input int u);
    frame_t f;
    logic   eb[16];
    int     db, os, nb, guard, qn;
    logic   prev, aborted, x;
    db = (u == 0) ? 8 : 7;
    os = (u == 0) ? 16 : 8;
    forever begin
      do @(negedge clk); while (line_tx(u) !== 1'b0);
      qn = (u == 0) ? q0.size() : q1.size();
      check($sformatf("m%0d_frame_expected", u), 32'(qn > 0), 1);
      if (qn == 0) begin
        while (line_busy(u) === 1'b1) @(negedge clk);
        continue;
      end
      if (u == 0) f = q0.pop_front();
      else        f = q1.pop_front();
      seen[u]++;
      check($sformatf("m%0d_start_on_tick", u), 32'(tick_at_pos), 1);
      x = 1'b0;
      for (int i = 0; i < db; i++) x ^= f.data[i];
      eb[0] = 1'b0;
      for (int i = 0; i < db; i++) eb[1 + i] = f.data[i];
      nb = 1 + db;
      if (f.pm != 2'b00) begin
        eb[nb] = (f.pm == 2'b01) ? x : (f.pm == 2'b10) ? ~x : 1'b1;
        nb++;
      end
      eb[nb] = 1'b1;
      nb++;
      if (f.s2) begin
        eb[nb] = 1'b1;
        nb++;
      end
      aborted = 1'b0;
      for (int k = 0; k < nb * os && !aborted; k++) begin
        check($sformatf("m%0d_bit%0d_tx", u, k / os), 32'(line_tx(u)), 32'(eb[k / os]));
        check($sformatf("m%0d_bit%0d_busy", u, k / os), 32'(line_busy(u)), 1);
        check($sformatf("m%0d_bit%0d_done", u, k / os), 32'(line_done(u)), 0);
        prev  = line_tx(u);
        guard = 0;
        forever begin
          @(negedge clk);
          guard++;
          if (rst_at_pos) begin
            check($sformatf("m%0d_rst_tx", u), 32'(line_tx(u)), 1);
            check($sformatf("m%0d_rst_busy", u), 32'(line_busy(u)), 0);
            check($sformatf("m%0d_rst_done", u), 32'(line_done(u)), 0);
            aborted = 1'b1;
            break;
          end
          if (tick_at_pos || guard > 1000) break;
          check($sformatf("m%0d_hold_tx", u), 32'(line_tx(u)), 32'(prev));
        end
        if (!aborted && !tick_at_pos) begin
          check($sformatf("m%0d_tick_seen", u), 32'(tick_at_pos), 1);
          aborted = 1'b1;
        end
      end
      if (!aborted) begin
        check($sformatf("m%0d_end_done", u), 32'(line_done(u)), 1);
        check($sformatf("m%0d_end_busy", u), 32'(line_busy(u)), 0);
        check($sformatf("m%0d_end_tx", u), 32'(line_tx(u)), 1);
        @(negedge clk);
        check($sformatf("m%0d_done_pulse", u), 32'(line_done(u)), 0);
      end
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);

  task automatic send_a(input logic [7:0] d, input logic [1:0] p, input logic s);
    frame_t f;
    @(negedge clk);
    start_a = 1'b1;
    data_a  = d;
    pm      = p;
    s2      = s;
    f.data  = 9'(d);
    f.pm    = p;
    f.s2    = s;
    q0.push_back(f);
    pushed[0]++;
    @(negedge clk);
    start_a = 1'b0;
    data_a  = ~d;
    pm      = ~p;
    s2      = ~s;
    check("a_busy_after_accept", 32'(busy_a), 1);
  endtask

  task automatic send_b(input logic [6:0] d, input logic [1:0] p, input logic s);
    frame_t f;
    @(negedge clk);
    start_b = 1'b1;
    data_b  = d;
    pm      = p;
    s2      = s;
    f.data  = 9'(d);
    f.pm    = p;
    f.s2    = s;
    q1.push_back(f);
    pushed[1]++;
    @(negedge clk);
    start_b = 1'b0;
    data_b  = ~d;
    pm      = ~p;
    s2      = ~s;
    check("b_busy_after_accept", 32'(busy_b), 1);
  endtask

  task automatic wait_done(input int u);
    int g;
    g = 0;
    while (line_done(u) !== 1'b1 && g < 4000) begin
      @(negedge clk);
      g++;
    end
    check($sformatf("w%0d_done_seen", u), 32'(line_done(u)), 1);
  endtask

  task automatic wait_tx_low(input int u);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (line_tx(u) !== 1'b0 && g < 2000);
    check($sformatf("w%0d_tx_low", u), 32'(line_tx(u)), 0);
  endtask

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(negedge clk);
      if (tick_at_pos) c++;
    end
  endtask

  initial begin
    #400000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    reset   = 1'b1;
    tick_en = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    data_a  = '0;
    data_b  = '0;
    pm      = '0;
    s2      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_a", 32'(tx_a), 1);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_done_a", 32'(done_a), 0);
    check("rst_tx_b", 32'(tx_b), 1);
    check("rst_busy_b", 32'(busy_b), 0);
    reset = 1'b0;
    @(negedge clk);

    send_a(8'hA5, 2'b00, 1'b0);
    wait_done(0);
    send_a(8'h07, 2'b10, 1'b0);
    wait_done(0);
    send_a(8'h07, 2'b11, 1'b0);
    wait_done(0);

    // Even parity with b_tick stalled mid parity bit
    send_a(8'h07, 2'b01, 1'b0);
    wait_tx_low(0);
    wait_ticks(9 * 16 + 8);
    tick_en = 1'b0;
    repeat (100) @(negedge clk);
    check("stall_tx", 32'(tx_a), 1);
    check("stall_busy", 32'(busy_a), 1);
    tick_en = 1'b1;
    wait_done(0);

    // Second request mid-frame is dropped
    send_a(8'h3C, 2'b00, 1'b0);
    wait_tx_low(0);
    wait_ticks(48);
    @(negedge clk);
    start_a = 1'b1;
    data_a  = 8'hFF;
    pm      = 2'b11;
    s2      = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("ignored_start_busy", 32'(busy_a), 1);
    wait_done(0);

    // Start in the cycle after tx_done
    send_a(8'hC3, 2'b01, 1'b1);
    wait_done(0);

    // Reset in data bit 4, then a clean frame
    send_a(8'h5A, 2'b00, 1'b0);
    wait_tx_low(0);
    wait_ticks(5 * 16 + 8);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_tx", 32'(tx_a), 1);
    check("abort_busy", 32'(busy_a), 0);
    check("abort_done", 32'(done_a), 0);
    send_a(8'h96, 2'b10, 1'b0);
    wait_done(0);

    for (int i = 0; i < 3; i++) begin
      send_a(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      wait_done(0);
    end

    send_b(7'h55, 2'b00, 1'b1);
    wait_done(1);
    send_b(7'h2A, 2'b01, 1'b0);
    wait_done(1);

    repeat (4) @(negedge clk);
    check("q0_empty", 32'(q0.size()), 0);
    check("q1_empty", 32'(q1.size()), 0);
    check("frames_a", 32'(seen[0]), 32'(pushed[0]));
    check("frames_b", 32'(seen[1]), 32'(pushed[1]));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
